// File: rtl/pwm_fade_ctrl.sv
// Fade sequencer for an R-bit PWM generator: ramps the duty up to a peak, holds it,
// then ramps it back to zero. Every duty update lands on a PWM period boundary.
module pwm_fade_ctrl #(
  parameter int R      = 8,
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [R-1:0]      target,
  input  logic [R-1:0]      step,
  input  logic [HOLD_W-1:0] hold_periods,
  output logic [R-1:0]      ciclo,
  output logic              busy,
  output logic              done,
  output logic              period_tick
);

  typedef enum logic [1:0] {IDLE, UP, HOLD, DOWN} state_t;

  state_t              state_q, state_d;
  logic [R-1:0]        pcnt_q;
  logic [R-1:0]        ciclo_q, ciclo_d;
  logic [HOLD_W-1:0]   hcnt_q, hcnt_d;
  logic [R-1:0]        tgt_q, tgt_d;
  logic [R-1:0]        stp_q, stp_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                done_q, done_d;
  logic                tick;
  logic [R:0]          up_sum;

  // Decrement that floors at zero instead of wrapping.
  function automatic logic [R-1:0] sat_sub(input logic [R-1:0] a, input logic [R-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  assign tick   = (pcnt_q == {R{1'b1}});
  assign up_sum = {1'b0, ciclo_q} + {1'b0, stp_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      ciclo_q <= '0;
      hcnt_q  <= '0;
      tgt_q   <= '0;
      stp_q   <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_q + 1'b1;
      ciclo_q <= ciclo_d;
      hcnt_q  <= hcnt_d;
      tgt_q   <= tgt_d;
      stp_q   <= stp_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ciclo_d = ciclo_q;
    hcnt_d  = hcnt_q;
    tgt_d   = tgt_q;
    stp_d   = stp_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      ciclo_d = '0;
      hcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            tgt_d   = target;
            stp_d   = (step == '0) ? R'(1) : step;
            hold_d  = hold_periods;
            state_d = UP;
          end
        end
        UP: begin
          if (tick) begin
            if (up_sum >= {1'b0, tgt_q}) begin
              ciclo_d = tgt_q;
              hcnt_d  = hold_q;
              state_d = HOLD;
            end else begin
              ciclo_d = up_sum[R-1:0];
            end
          end
        end
        HOLD: begin
          // Leaving HOLD already applies the first downward step.
          if (tick) begin
            if (hcnt_q == '0) begin
              ciclo_d = sat_sub(ciclo_q, stp_q);
              state_d = DOWN;
            end else begin
              hcnt_d = hcnt_q - 1'b1;
            end
          end
        end
        DOWN: begin
          if (tick) begin
            if (ciclo_q <= stp_q) begin
              ciclo_d = '0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              ciclo_d = ciclo_q - stp_q;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ciclo       = ciclo_q;
    busy        = (state_q != IDLE);
    done        = done_q;
    period_tick = tick;
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl (R = 8): table of fade profiles with per-tick expected duty,
// plus directed reset, abort and ignored-start sequences.
module tb_pwm_fade_ctrl;

  localparam int R      = 8;
  localparam int HOLD_W = 8;
  localparam int MAXN   = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [R-1:0]      target;
  logic [R-1:0]      step;
  logic [HOLD_W-1:0] hold_periods;
  logic [R-1:0]      ciclo;
  logic              busy;
  logic              done;
  logic              period_tick;

  pwm_fade_ctrl #(.R(R), .HOLD_W(HOLD_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .target       (target),
    .step         (step),
    .hold_periods (hold_periods),
    .ciclo        (ciclo),
    .busy         (busy),
    .done         (done),
    .period_tick  (period_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [R-1:0]      tgt;
    logic [R-1:0]      stp;
    logic [HOLD_W-1:0] hld;
    int                n;
    int                seq [MAXN];
  } vec_t;

  typedef struct {
    int ciclo;
    bit last;
  } exp_t;

  vec_t vecs [5];
  exp_t sb [$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Waits (sampling on negedges) until period_tick is high; bounded.
  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (period_tick) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("tick_timeout", 0, 1);
  endtask

  task automatic do_start(input logic [R-1:0] t, input logic [R-1:0] s, input logic [HOLD_W-1:0] h);
    @(negedge clk);
    target = t; step = s; hold_periods = h; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Runs one table profile; inject=1 pulses a conflicting start after the first tick.
  task automatic run_case(input int idx, input bit inject);
    bit   ok;
    int   prev;
    exp_t e;
    for (int k = 0; k < vecs[idx].n; k++) begin
      e.ciclo = vecs[idx].seq[k];
      e.last  = (k == vecs[idx].n - 1);
      sb.push_back(e);
    end
    do_start(vecs[idx].tgt, vecs[idx].stp, vecs[idx].hld);
    @(negedge clk);
    chk($sformatf("c%0d_busy_start", idx), busy, 1);
    prev = 0;
    while (sb.size() > 0) begin
      wait_tick(ok);
      if (!ok) begin
        sb.delete();
        break;
      end
      chk($sformatf("c%0d_stable_before_tick", idx), ciclo, prev);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("c%0d_ciclo", idx), ciclo, e.ciclo);
      chk($sformatf("c%0d_done", idx), done, e.last);
      chk($sformatf("c%0d_busy", idx), busy, !e.last);
      prev = e.ciclo;
      if (inject && prev == vecs[idx].seq[0] && !e.last) begin
        inject = 1'b0;
        target = 8'd50; step = 8'd1; hold_periods = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    @(negedge clk);
    chk($sformatf("c%0d_done_one_cycle", idx), done, 0);
    chk($sformatf("c%0d_idle_after", idx), busy, 0);
  endtask

  initial begin
    bit ok;
    int edges;
    int seen_done;

    vecs[0] = '{tgt: 8'd100, stp: 8'd30,  hld: 8'd2, n: 10,
                seq: '{30, 60, 90, 100, 100, 100, 70, 40, 10, 0, 0, 0}};
    vecs[1] = '{tgt: 8'd255, stp: 8'd200, hld: 8'd0, n: 4,
                seq: '{200, 255, 55, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[2] = '{tgt: 8'd3,   stp: 8'd0,   hld: 8'd1, n: 7,
                seq: '{1, 2, 3, 3, 2, 1, 0, 0, 0, 0, 0, 0}};
    vecs[3] = '{tgt: 8'd0,   stp: 8'd5,   hld: 8'd0, n: 3,
                seq: '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[4] = '{tgt: 8'd10,  stp: 8'd4,   hld: 8'd0, n: 6,
                seq: '{4, 8, 10, 6, 2, 0, 0, 0, 0, 0, 0, 0}};

    reset = 1'b1; start = 1'b0; abort = 1'b0;
    target = '0; step = '0; hold_periods = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ciclo", ciclo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tick", period_tick, 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_case(i, 1'b0);

    // Conflicting start during UP must not restart or alter the profile.
    run_case(0, 1'b1);

    // Abort in HOLD, mid-period.
    do_start(8'd100, 8'd30, 8'd2);
    for (int i = 0; i < 4; i++) wait_tick(ok);
    @(negedge clk);
    chk("abort_pre_peak", ciclo, 100);
    repeat (20) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ciclo", ciclo, 0);
    chk("abort_busy", busy, 0);
    chk("abort_tick_low", period_tick, 0);
    seen_done = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done || ciclo != 0) seen_done++;
    end
    chk("abort_quiet_after", seen_done, 0);

    // start together with abort in IDLE is dropped.
    @(negedge clk);
    target = 8'd40; step = 8'd10; hold_periods = '0;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    wait_tick(ok);
    @(negedge clk);
    chk("start_abort_ciclo", ciclo, 0);

    // Asynchronous reset in the middle of UP.
    do_start(8'd100, 8'd30, 8'd2);
    for (int i = 0; i < 2; i++) wait_tick(ok);
    repeat (40) @(negedge clk);
    chk("pre_reset_ciclo", ciclo, 60);
    #2 reset = 1'b1;
    #1;
    chk("arst_ciclo", ciclo, 0);
    chk("arst_busy", busy, 0);
    chk("arst_tick", period_tick, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    edges = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      edges++;
      #1;
      if (period_tick) break;
    end
    chk("arst_first_tick_edges", edges, 255);
    edges = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      edges++;
      #1;
      if (period_tick) break;
    end
    chk("arst_period_edges", edges, 256);
    chk("arst_idle_after", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
